// File: rtl/ldtu_bsl_calib.sv
// LiTe-DTU baseline calibration controller: settles, averages a block of gain_10
// then gain_01 samples through one accumulator, and drives the 8-bit baselines.
module ldtu_bsl_calib #(
  parameter int Nbits_12 = 12,
  parameter int Nbits_8  = 8,
  parameter int LOG2_NS  = 4,
  parameter int SETTLE   = 8,
  parameter int MARGIN   = 8
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                CAL_START,
  input  logic                CAL_ABORT,
  input  logic                MAN_SEL,
  input  logic [Nbits_8-1:0]  BSL_MAN_g01,
  input  logic [Nbits_8-1:0]  BSL_MAN_g10,
  input  logic [Nbits_12-1:0] DATA12_g01,
  input  logic [Nbits_12-1:0] DATA12_g10,
  output logic [Nbits_8-1:0]  BSL_VAL_g01,
  output logic [Nbits_8-1:0]  BSL_VAL_g10,
  output logic                CAL_BUSY,
  output logic                CAL_DONE,
  output logic                CAL_OVF
);

  localparam int AW = Nbits_12 + LOG2_NS;
  localparam int NS = 1 << LOG2_NS;
  localparam int CW = (LOG2_NS + 1 > 8) ? LOG2_NS + 1 : 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACC_G10,
    ST_ACC_G01,
    ST_UPDATE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [AW-1:0]       r_acc;
  logic [Nbits_8-1:0]  r_hold_g10;
  logic [Nbits_8-1:0]  r_hold_g01;
  logic [Nbits_8-1:0]  r_cal_g10;
  logic [Nbits_8-1:0]  r_cal_g01;
  logic                r_done;
  logic                r_ovf;

  logic                w_start;
  logic                w_last_settle;
  logic                w_last_smp;
  logic [Nbits_12-1:0] w_data;
  logic [AW-1:0]       w_sum;
  logic [Nbits_12-1:0] w_mean;
  logic [Nbits_12-1:0] w_d;
  logic                w_res_ovf;
  logic [Nbits_8-1:0]  w_res;

  assign w_start       = CAL_START && !CAL_ABORT;
  assign w_last_settle = (r_cnt == CW'(SETTLE - 1));
  assign w_last_smp    = (r_cnt == CW'(NS - 1));

  // The sum includes the current sample so the final sample lands in the result.
  always_comb begin
    w_data    = (r_state == ST_ACC_G10) ? DATA12_g10 : DATA12_g01;
    w_sum     = r_acc + AW'(w_data);
    w_mean    = Nbits_12'(w_sum >> LOG2_NS);
    w_d       = (w_mean >= Nbits_12'(MARGIN)) ? (w_mean - Nbits_12'(MARGIN)) : '0;
    w_res_ovf = (w_d > Nbits_12'((1 << Nbits_8) - 1));
    w_res     = w_res_ovf ? '1 : Nbits_8'(w_d);
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_SETTLE;
      ST_SETTLE:  if (CAL_ABORT) w_next = ST_IDLE;
                  else if (w_last_settle) w_next = ST_ACC_G10;
      ST_ACC_G10: if (CAL_ABORT) w_next = ST_IDLE;
                  else if (w_last_smp) w_next = ST_ACC_G01;
      ST_ACC_G01: if (CAL_ABORT) w_next = ST_IDLE;
                  else if (w_last_smp) w_next = ST_UPDATE;
      ST_UPDATE:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_hold_g10 <= '0;
      r_hold_g01 <= '0;
      r_cal_g10  <= '0;
      r_cal_g01  <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!CAL_ABORT) begin
            if (w_last_settle) begin
              r_cnt <= '0;
              r_acc <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ACC_G10, ST_ACC_G01: begin
          if (!CAL_ABORT) begin
            if (w_last_smp) begin
              if (r_state == ST_ACC_G10) r_hold_g10 <= w_res;
              else                       r_hold_g01 <= w_res;
              if (w_res_ovf) r_ovf <= 1'b1;
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          r_cal_g10 <= r_hold_g10;
          r_cal_g01 <= r_hold_g01;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BSL_VAL_g01 = MAN_SEL ? BSL_MAN_g01 : r_cal_g01;
  assign BSL_VAL_g10 = MAN_SEL ? BSL_MAN_g10 : r_cal_g10;
  assign CAL_BUSY    = (r_state != ST_IDLE);
  assign CAL_DONE    = r_done;
  assign CAL_OVF     = r_ovf;

endmodule
